// File: rtl/mp_regfile_sb_pkg.sv
// Shared constants and types for the multi-ported register file with scoreboard.
// Tags are stored zero-extended to SB_TAG_MAX bits so one entry type serves every TAGW.
package mp_regfile_sb_pkg;

    localparam int DEF_XLEN   = 32;
    localparam int DEF_NREGS  = 32;
    localparam int DEF_NRD    = 2;
    localparam int DEF_NWR    = 2;
    localparam int DEF_TAGW   = 4;
    localparam int SB_TAG_MAX = 8;

    localparam logic [DEF_XLEN-1:0] ZERO_WORD = '0;

    typedef struct packed {
        logic                  pending;
        logic [SB_TAG_MAX-1:0] owner;
    } sb_entry_t;

    localparam sb_entry_t SB_IDLE = '{pending: 1'b0, owner: '0};

endpackage

// File: rtl/mp_regfile_sb_scoreboard.sv
// Per-register pending/owner scoreboard with operand-ready lookup for every read port.
// A completing write only retires the producer whose tag still owns the register.
module regfile_scoreboard
    import mp_regfile_sb_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int NRD   = DEF_NRD,
    parameter int NWR   = DEF_NWR,
    parameter int TAGW  = DEF_TAGW,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_rdy,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic [NWR*TAGW-1:0] wr_tag,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    input  logic [TAGW-1:0]   iss_tag,
    input  logic              flush
);

    sb_entry_t sb_q [NREGS];
    sb_entry_t sb_d [NREGS];

    // Order inside the loop sets priority: retire, then issue, then flush.
    always_comb begin
        sb_d = sb_q;
        for (int r = 1; r < NREGS; r++) begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && wr_addr[w*AW +: AW] == AW'(r) &&
                    sb_q[r].owner == SB_TAG_MAX'(wr_tag[w*TAGW +: TAGW])) begin
                    sb_d[r].pending = 1'b0;
                end
            end
            if (iss_valid && iss_rd == AW'(r)) begin
                sb_d[r].pending = 1'b1;
                sb_d[r].owner   = SB_TAG_MAX'(iss_tag);
            end
            if (flush) begin
                sb_d[r].pending = 1'b0;
            end
        end
        sb_d[0] = SB_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                sb_q[r] <= SB_IDLE;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                sb_q[r] <= sb_d[r];
            end
        end
    end

    always_comb begin : ready_lookup
        logic [AW-1:0] a;
        logic          ready;
        rd_rdy = '0;
        a      = '0;
        ready  = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            a     = rd_addr[p*AW +: AW];
            ready = !sb_q[a].pending;
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && a != '0 && wr_addr[w*AW +: AW] == a &&
                    sb_q[a].owner == SB_TAG_MAX'(wr_tag[w*TAGW +: TAGW])) begin
                    ready = 1'b1;
                end
            end
            rd_rdy[p] = ready;
        end
    end

endmodule

// File: rtl/mp_regfile_sb.sv
// Multi-ported register file with same-cycle write bypass and a producer scoreboard.
// Register 0 is hardwired to zero; the data array and bypass live here.
module mp_regfile_sb
    import mp_regfile_sb_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREGS = DEF_NREGS,
    parameter int NRD   = DEF_NRD,
    parameter int NWR   = DEF_NWR,
    parameter int TAGW  = DEF_TAGW,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_rdy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic [NWR*TAGW-1:0] wr_tag,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    input  logic [TAGW-1:0]     iss_tag,
    input  logic                flush
);

    logic [XLEN-1:0] regs [NREGS];

    // Later ports overwrite earlier ones, so the highest-indexed port wins a collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= XLEN'(ZERO_WORD);
            end
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && wr_addr[w*AW +: AW] != '0) begin
                    regs[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin : read_mux
        logic [AW-1:0]   a;
        logic [XLEN-1:0] v;
        rd_data = '0;
        a       = '0;
        v       = '0;
        for (int p = 0; p < NRD; p++) begin
            a = rd_addr[p*AW +: AW];
            v = regs[a];
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && wr_addr[w*AW +: AW] == a) begin
                    v = wr_data[w*XLEN +: XLEN];
                end
            end
            // Reset holds the array at zero, but the bypass path must be gated too.
            if (rst || a == '0) begin
                v = XLEN'(ZERO_WORD);
            end
            rd_data[p*XLEN +: XLEN] = v;
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR),
        .TAGW  (TAGW)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_rdy    (rd_rdy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_tag    (wr_tag),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_tag   (iss_tag),
        .flush     (flush)
    );

endmodule

// File: tb/tb_mp_regfile_sb.sv
// Bench for mp_regfile_sb: directed scenarios with constant expectations, then
// randomized traffic against an array-based reference of the register file and scoreboard.
module tb_mp_regfile_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int TAGW  = 4;
    localparam int AW    = 5;

    logic                clk;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_rdy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic [NWR*TAGW-1:0] wr_tag;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic [TAGW-1:0]     iss_tag;
    logic                flush;

    int checks = 0;
    int errors = 0;

    // Reference state: architectural registers plus pending/owner per register.
    logic [XLEN-1:0] m_mem [NREGS];
    bit              m_pend [NREGS];
    logic [TAGW-1:0] m_own [NREGS];

    mp_regfile_sb #(
        .XLEN (XLEN), .NREGS (NREGS), .NRD (NRD), .NWR (NWR), .TAGW (TAGW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_rdy    (rd_rdy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_tag    (wr_tag),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_tag   (iss_tag),
        .flush     (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_idle();
        rd_addr   = '0;
        wr_en     = '0;
        wr_addr   = '0;
        wr_data   = '0;
        wr_tag    = '0;
        iss_valid = 1'b0;
        iss_rd    = '0;
        iss_tag   = '0;
        flush     = 1'b0;
    endtask

    task automatic set_read(input int p, input int a);
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic set_write(input int w, input logic en, input int a,
                             input logic [XLEN-1:0] d, input int t);
        wr_en[w]                = en;
        wr_addr[w*AW +: AW]     = AW'(a);
        wr_data[w*XLEN +: XLEN] = d;
        wr_tag[w*TAGW +: TAGW]  = TAGW'(t);
    endtask

    task automatic set_issue(input logic v, input int a, input int t);
        iss_valid = v;
        iss_rd    = AW'(a);
        iss_tag   = TAGW'(t);
    endtask

    function automatic logic [XLEN-1:0] dut_data(input int p);
        return rd_data[p*XLEN +: XLEN];
    endfunction

    // Reference read: zero for x0/reset, else newest same-cycle write, else stored value.
    function automatic logic [XLEN-1:0] m_data(input int p);
        int a;
        logic [XLEN-1:0] v;
        a = int'(rd_addr[p*AW +: AW]);
        if (rst || a == 0) return '0;
        v = m_mem[a];
        for (int w = 0; w < NWR; w++)
            if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == a) v = wr_data[w*XLEN +: XLEN];
        return v;
    endfunction

    function automatic logic m_rdy(input int p);
        int a;
        a = int'(rd_addr[p*AW +: AW]);
        if (rst || a == 0 || !m_pend[a]) return 1'b1;
        for (int w = 0; w < NWR; w++)
            if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == a &&
                wr_tag[w*TAGW +: TAGW] == m_own[a]) return 1'b1;
        return 1'b0;
    endfunction

    // Apply what the clock edge does, based on the inputs held across it.
    task automatic model_commit();
        bit              old_pend [NREGS];
        logic [TAGW-1:0] old_own [NREGS];
        int a;
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                m_mem[r] = '0; m_pend[r] = 0; m_own[r] = '0;
            end
            return;
        end
        old_pend = m_pend;
        old_own  = m_own;
        for (int w = 0; w < NWR; w++) begin
            a = int'(wr_addr[w*AW +: AW]);
            if (wr_en[w] && a != 0) begin
                m_mem[a] = wr_data[w*XLEN +: XLEN];
                if (old_pend[a] && old_own[a] == wr_tag[w*TAGW +: TAGW]) m_pend[a] = 0;
            end
        end
        if (iss_valid && iss_rd != '0) begin
            m_pend[int'(iss_rd)] = 1;
            m_own[int'(iss_rd)]  = iss_tag;
        end
        if (flush)
            for (int r = 0; r < NREGS; r++) m_pend[r] = 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        set_read(0, 5);
        set_read(1, 6);
        set_write(0, 1'b1, 5, 32'hAA, 0);
        set_issue(1'b1, 6, 1);
        flush = 1'b1;
        @(negedge clk);
        checks++;
        if (dut_data(0) !== 32'h0) begin
            errors++; $display("FAIL reset_data: got %h want %h", dut_data(0), 32'h0);
        end
        checks++;
        if (rd_rdy !== 2'b11) begin
            errors++; $display("FAIL reset_rdy: got %b want %b", rd_rdy, 2'b11);
        end
        step();
        rst = 1'b0;
        drive_idle();
        set_read(0, 5);
        set_read(1, 6);
        @(negedge clk);
        checks++;
        if (dut_data(0) !== 32'h0) begin
            errors++; $display("FAIL reset_ignores_write: got %h want %h", dut_data(0), 32'h0);
        end
        checks++;
        if (rd_rdy !== 2'b11) begin
            errors++; $display("FAIL reset_ignores_issue: got %b want %b", rd_rdy, 2'b11);
        end
        step();
    endtask

    task automatic test_x0();
        drive_idle();
        set_write(1, 1'b1, 0, 32'hDEADBEEF, 0);
        set_issue(1'b1, 0, 3);
        set_read(0, 0);
        @(negedge clk);
        checks++;
        if (dut_data(0) !== 32'h0 || rd_rdy[0] !== 1'b1) begin
            errors++; $display("FAIL x0_same_cycle: got %h/%b want 0/1", dut_data(0), rd_rdy[0]);
        end
        step();
        drive_idle();
        set_read(0, 0);
        @(negedge clk);
        checks++;
        if (dut_data(0) !== 32'h0 || rd_rdy[0] !== 1'b1) begin
            errors++; $display("FAIL x0_after_write: got %h/%b want 0/1", dut_data(0), rd_rdy[0]);
        end
        step();
    endtask

    task automatic test_same_addr();
        drive_idle();
        set_write(0, 1'b1, 3, 32'h11, 0);
        set_write(1, 1'b1, 3, 32'h22, 0);
        set_read(1, 3);
        @(negedge clk);
        checks++;
        if (dut_data(1) !== 32'h22) begin
            errors++; $display("FAIL same_addr_bypass: got %h want %h", dut_data(1), 32'h22);
        end
        step();
        drive_idle();
        set_read(0, 3);
        @(negedge clk);
        checks++;
        if (dut_data(0) !== 32'h22) begin
            errors++; $display("FAIL same_addr_stored: got %h want %h", dut_data(0), 32'h22);
        end
        step();
    endtask

    task automatic test_bypass_issue();
        drive_idle();
        set_issue(1'b1, 7, 2);
        step();
        drive_idle();
        set_read(0, 7);
        @(negedge clk);
        checks++;
        if (rd_rdy[0] !== 1'b0) begin
            errors++; $display("FAIL issue_pending: got %b want 0", rd_rdy[0]);
        end
        set_write(0, 1'b1, 7, 32'h55, 2);
        #1;
        checks++;
        if (dut_data(0) !== 32'h55 || rd_rdy[0] !== 1'b1) begin
            errors++; $display("FAIL complete_bypass: got %h/%b want 55/1", dut_data(0), rd_rdy[0]);
        end
        step();
        drive_idle();
        set_read(0, 7);
        @(negedge clk);
        checks++;
        if (dut_data(0) !== 32'h55 || rd_rdy[0] !== 1'b1) begin
            errors++; $display("FAIL complete_after: got %h/%b want 55/1", dut_data(0), rd_rdy[0]);
        end
        step();
    endtask

    task automatic test_stale_tag();
        drive_idle();
        set_issue(1'b1, 7, 2);
        step();
        set_issue(1'b1, 7, 3);
        step();
        drive_idle();
        set_read(1, 7);
        set_write(0, 1'b1, 7, 32'h66, 2);
        @(negedge clk);
        checks++;
        if (rd_rdy[1] !== 1'b0 || dut_data(1) !== 32'h66) begin
            errors++; $display("FAIL stale_same_cycle: got %h/%b want 66/0", dut_data(1), rd_rdy[1]);
        end
        step();
        drive_idle();
        set_read(1, 7);
        @(negedge clk);
        checks++;
        if (rd_rdy[1] !== 1'b0 || dut_data(1) !== 32'h66) begin
            errors++; $display("FAIL stale_after: got %h/%b want 66/0", dut_data(1), rd_rdy[1]);
        end
        set_write(1, 1'b1, 7, 32'h77, 3);
        step();
        drive_idle();
        set_read(1, 7);
        @(negedge clk);
        checks++;
        if (rd_rdy[1] !== 1'b1 || dut_data(1) !== 32'h77) begin
            errors++; $display("FAIL owner_retire: got %h/%b want 77/1", dut_data(1), rd_rdy[1]);
        end
        step();
        // Issue and matching-tag completion on the same register: the new issue survives.
        drive_idle();
        set_issue(1'b1, 8, 5);
        step();
        set_issue(1'b1, 8, 6);
        set_write(0, 1'b1, 8, 32'h88, 5);
        set_read(0, 8);
        @(negedge clk);
        checks++;
        if (rd_rdy[0] !== 1'b1) begin
            errors++; $display("FAIL issue_vs_write_same_cycle: got %b want 1", rd_rdy[0]);
        end
        step();
        drive_idle();
        set_read(0, 8);
        @(negedge clk);
        checks++;
        if (rd_rdy[0] !== 1'b0) begin
            errors++; $display("FAIL issue_wins: got %b want 0", rd_rdy[0]);
        end
        step();
    endtask

    task automatic test_flush();
        drive_idle();
        set_issue(1'b1, 9, 1);
        flush = 1'b1;
        step();
        drive_idle();
        set_read(0, 9);
        @(negedge clk);
        checks++;
        if (rd_rdy[0] !== 1'b1) begin
            errors++; $display("FAIL flush_beats_issue: got %b want 1", rd_rdy[0]);
        end
        set_issue(1'b1, 10, 4);
        step();
        drive_idle();
        flush = 1'b1;
        set_write(0, 1'b1, 10, 32'h99, 0);
        step();
        drive_idle();
        set_read(0, 10);
        @(negedge clk);
        checks++;
        if (rd_rdy[0] !== 1'b1 || dut_data(0) !== 32'h99) begin
            errors++; $display("FAIL flush_keeps_data: got %h/%b want 99/1", dut_data(0), rd_rdy[0]);
        end
        step();
    endtask

    task automatic test_reset_mid();
        drive_idle();
        set_issue(1'b1, 4, 3);
        step();
        drive_idle();
        set_write(0, 1'b1, 4, 32'h44, 0);
        set_read(0, 4);
        @(negedge clk);
        checks++;
        if (rd_rdy[0] !== 1'b0 || dut_data(0) !== 32'h44) begin
            errors++; $display("FAIL mid_pending: got %h/%b want 44/0", dut_data(0), rd_rdy[0]);
        end
        step();
        drive_idle();
        set_read(0, 4);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (rd_rdy[0] !== 1'b1 || dut_data(0) !== 32'h0) begin
            errors++; $display("FAIL mid_rst_async: got %h/%b want 0/1", dut_data(0), rd_rdy[0]);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_rdy[0] !== 1'b1 || dut_data(0) !== 32'h0) begin
            errors++; $display("FAIL post_rst: got %h/%b want 0/1", dut_data(0), rd_rdy[0]);
        end
        step();
    endtask

    task automatic test_random();
        logic [XLEN-1:0] exp_d;
        logic            exp_r;
        rst = 1'b1;
        drive_idle();
        step();
        rst = 1'b0;
        for (int c = 0; c < 500; c++) begin
            drive_idle();
            for (int p = 0; p < NRD; p++) set_read(p, $urandom_range(0, 7));
            for (int w = 0; w < NWR; w++)
                set_write(w, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom,
                          $urandom_range(0, 3));
            set_issue(1'($urandom_range(0, 2) == 0), $urandom_range(0, 7), $urandom_range(0, 3));
            flush = ($urandom_range(0, 15) == 0);
            rst   = ($urandom_range(0, 63) == 0);
            @(negedge clk);
            for (int p = 0; p < NRD; p++) begin
                exp_d = m_data(p);
                exp_r = m_rdy(p);
                checks++;
                if (dut_data(p) !== exp_d) begin
                    errors++;
                    $display("FAIL rand_data c=%0d p=%0d: got %h want %h", c, p, dut_data(p), exp_d);
                end
                checks++;
                if (rd_rdy[p] !== exp_r) begin
                    errors++;
                    $display("FAIL rand_rdy c=%0d p=%0d: got %b want %b", c, p, rd_rdy[p], exp_r);
                end
            end
            step();
        end
        rst = 1'b0;
        drive_idle();
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        for (int r = 0; r < NREGS; r++) begin
            m_mem[r] = '0; m_pend[r] = 0; m_own[r] = '0;
        end
        #1;
        test_reset();
        test_x0();
        test_same_addr();
        test_bypass_issue();
        test_stale_tag();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mp_regfile_sb.md
MP_REGFILE_SB -- requirements
Module: mp_regfile_sb

Interface
REQ-001 SHALL provide parameter XLEN, default 32, data width in bits.
REQ-002 SHALL provide parameter NREGS, default 32, register count (power of two, >=2); AW = log2(NREGS).
REQ-003 SHALL provide parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL provide parameter NWR, default 2, number of write ports (1..2).
REQ-005 SHALL provide parameter TAGW, default 4, producer tag width.
REQ-006 clk  in  1  clock, all state updates on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 rd_addr  in  NRD*AW  read addresses, port p in slice p.
REQ-009 rd_data  out  NRD*XLEN  read data, combinational.
REQ-010 rd_rdy  out  NRD  operand ready (no outstanding producer), combinational.
REQ-011 wr_en  in  NWR  write enables.
REQ-012 wr_addr  in  NWR*AW  write addresses.
REQ-013 wr_data  in  NWR*XLEN  write data.
REQ-014 wr_tag  in  NWR*TAGW  tag of the producer completing on each write port.
REQ-015 iss_valid  in  1  instruction issue marks a destination pending.
REQ-016 iss_rd  in  AW  destination of issuing instruction.
REQ-017 iss_tag  in  TAGW  tag of issuing instruction.
REQ-018 flush  in  1  synchronous clear of all pending state (data untouched).

Function
REQ-019 Register 0 SHALL read as zero with rd_rdy=1; writes and issues to address 0 SHALL be ignored.
REQ-020 Write: on clock edge, each wr_en port with nonzero address SHALL update its register; when two ports target the same address, the higher-indexed port SHALL win.
REQ-021 Read bypass: if any enabled write port matches a read address in the same cycle, rd_data SHALL return that write data (highest-indexed match), else stored value.
REQ-022 Scoreboard: per register SHALL hold pending bit plus TAGW-bit owner tag.
REQ-023 iss_valid with nonzero iss_rd SHALL set pending[iss_rd]=1 and owner=iss_tag at next edge, overwriting any prior owner.
REQ-024 An enabled write SHALL clear pending[wr_addr] only when wr_tag equals the stored owner; a stale-tag write SHALL update data but leave pending set.
REQ-025 Same-cycle issue and matching-tag write to the same register SHALL leave pending=1 with owner=iss_tag (issue wins).
REQ-026 rd_rdy[p] SHALL be 1 when the register is not pending, or when an enabled write this cycle matches both its address and owner tag.
REQ-027 flush SHALL clear all pending bits at next edge and take priority over simultaneous issue; same-cycle writes SHALL still update data.
REQ-028 Read latency SHALL be zero cycles; write and scoreboard update latency SHALL be one edge.

Reset
REQ-029 rst SHALL asynchronously clear all registers to zero, all pending bits and owner tags to zero.
REQ-030 During rst, rd_data SHALL be zero and rd_rdy SHALL be all ones; writes, issues and flush SHALL be ignored.
REQ-031 Assertion mid-operation SHALL discard all pending producers; no state survives.

Structure
REQ-032 Shared package SHALL hold default XLEN/NREGS/TAGW constants, the zero-word constant and a scoreboard-entry typedef (pending bit + tag).
REQ-033 Scoreboard SHALL be a sub-module named regfile_scoreboard; data array and bypass stay in mp_regfile_sb.

Verification
REQ-034 Reset then read x5 on port 0 -> rd_data=0, rd_rdy=1; write x0=0xDEADBEEF then read x0 -> 0, rdy=1.
REQ-035 Write x3=0x11 port0 and x3=0x22 port1 same cycle, read x3 same cycle -> 0x22, next cycle stored 0x22.
REQ-036 Issue x7 tag 2, next cycle read x7 -> rdy=0; write x7=0x55 tag 2 -> same-cycle rd_data=0x55, rdy=1; following cycle rdy=1.
REQ-037 Issue x7 tag 2 then tag 3; write x7 tag 2 -> rdy stays 0; write x7 tag 3 -> rdy=1.
REQ-038 Issue x9 tag 1 with flush same cycle -> x9 rdy=1 next cycle; assert rst while x4 pending -> x4 reads 0, rdy=1.
